// File: rtl/gccnb_updown.sv
`default_nettype none
// ============================================================================
// Module      : gccnb_updown
// Description : WIDTH-bit Gray-code up/down counter with enable, clear,
//               parallel Gray load, binary shadow output and wrap pulse.
//               Define GCCNB_SAT_EN to saturate at the ends instead of
//               wrapping; this also adds the registered 'sat' output.
// Revision    : 1.0 - initial release
// ============================================================================
module gccnb_updown #(
    parameter int WIDTH   = 4,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
`ifdef GCCNB_SAT_EN
    ,
    output logic             sat
`endif
);

    localparam logic [WIDTH-1:0] C_RST_BIN = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] C_MAX     = '1;
    localparam logic [WIDTH-1:0] C_ZERO    = '0;
    localparam logic [WIDTH-1:0] C_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_b;
    logic             r_wrap;
    logic [WIDTH-1:0] w_b_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_load_bin;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        w_load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_load_bin[i] = ^(load_val >> i);
        end
    end

    always_comb begin
        w_b_next    = r_b;
        w_wrap_next = 1'b0;
        if (clr) begin
            w_b_next = C_RST_BIN;
        end else if (load) begin
            w_b_next = w_load_bin;
        end else if (en) begin
            if (up) begin
`ifdef GCCNB_SAT_EN
                if (r_b != C_MAX) w_b_next = r_b + C_ONE;
`else
                w_b_next    = r_b + C_ONE;
                w_wrap_next = (r_b == C_MAX);
`endif
            end else begin
`ifdef GCCNB_SAT_EN
                if (r_b != C_ZERO) w_b_next = r_b - C_ONE;
`else
                w_b_next    = r_b - C_ONE;
                w_wrap_next = (r_b == C_ZERO);
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b    <= C_RST_BIN;
            r_wrap <= 1'b0;
        end else begin
            r_b    <= w_b_next;
            r_wrap <= w_wrap_next;
        end
    end

`ifdef GCCNB_SAT_EN
    logic r_sat;

    // Flags the limit in the direction currently requested, refreshed every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else begin
            r_sat <= (w_b_next == (up ? C_MAX : C_ZERO));
        end
    end

    assign sat = r_sat;
`endif

    assign q    = r_b ^ (r_b >> 1);
    assign qbar = ~q;
    assign bin  = r_b;
    assign wrap = r_wrap;

endmodule
`default_nettype wire
